// File: rtl/m72_pkg.sv
// Shared definitions for the M72 SDRAM arbitration slice.
//   arb_state_e : arbiter FSM states (also exported on the debug port)
//   SDR_AW/SDR_DW : default SDRAM word-address / data widths
//   rr_next()   : round-robin pointer advance with wrap at nreq
package m72_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_DONE  = 2'd3
  } arb_state_e;

  localparam int SDR_AW = 24;
  localparam int SDR_DW = 16;

  // Next search start after serving idx: idx+1, wrapping to 0 at nreq.
  function automatic logic [1:0] rr_next(input logic [1:0] idx, input int nreq);
    if (int'(idx) + 1 >= nreq) return 2'd0;
    return idx + 2'd1;
  endfunction

endpackage

// File: rtl/m72_rr_pick.sv
// Combinational round-robin first-set finder.
//   pend   in  NREQ  pending request vector
//   rr_ptr in  2     index to start searching from (upward, mod NREQ)
//   grant  out 2     first pending index at or after rr_ptr
//   any    out 1     at least one request pending
module m72_rr_pick
  import m72_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0] pend,
  input  logic [1:0]      rr_ptr,
  output logic [1:0]      grant,
  output logic            any
);

  int idx;

  // Walk offsets from farthest to nearest so the nearest pending index wins.
  always_comb begin
    grant = 2'd0;
    idx   = 0;
    any   = |pend;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (pend[idx]) grant = idx[1:0];
    end
  end

endmodule

// File: rtl/m72_sdr_arbiter.sv
// Shares one toggle-handshake SDRAM port between NREQ requesters
// (port 0 = main CPU, then audio Z80 ROM, sample ROM). Round-robin grant,
// one SDRAM transaction in flight, read data registered and returned on a
// shared rq_dout tagged by rq_owner.
//
// Handshake (both sides): a port is pending when its req toggle differs from
// its ack toggle; the responder completes it by toggling ack back to equality.
// Requesters hold addr/wr_sel/din stable while pending and sample rq_dout on
// seeing their rq_ack bit toggle.
//
// Ports:
//   CLK_32M, reset_n (async, active-low)
//   rq_req/rq_ack      per-requester toggle handshake
//   rq_addr/rq_wr_sel/rq_din  per-requester request payload (slice i)
//   rq_dout, rq_owner  result data and index of its owner
//   sdr_req/sdr_ack, sdr_addr/sdr_wr_sel/sdr_din/sdr_dout  SDRAM port
//   busy               SDRAM transaction in flight
//   dbg_state          current FSM state
module m72_sdr_arbiter
  import m72_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW   = SDR_AW,
  parameter int DW   = SDR_DW
) (
  input  logic              CLK_32M,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   rq_req,
  output logic [NREQ-1:0]   rq_ack,
  input  logic [NREQ*AW-1:0] rq_addr,
  input  logic [NREQ*2-1:0] rq_wr_sel,
  input  logic [NREQ*DW-1:0] rq_din,
  output logic [DW-1:0]     rq_dout,
  output logic [1:0]        rq_owner,
  output logic              sdr_req,
  input  logic              sdr_ack,
  output logic [AW-1:0]     sdr_addr,
  output logic [1:0]        sdr_wr_sel,
  output logic [DW-1:0]     sdr_din,
  input  logic [DW-1:0]     sdr_dout,
  output logic              busy,
  output arb_state_e        dbg_state
);

  arb_state_e      state_q, state_d;
  logic [NREQ-1:0] rq_ack_q, rq_ack_d;
  logic [1:0]      owner_q, owner_d;
  logic [1:0]      rr_ptr_q, rr_ptr_d;
  logic            sdr_req_q, sdr_req_d;
  logic [AW-1:0]   sdr_addr_q, sdr_addr_d;
  logic [1:0]      sdr_wr_sel_q, sdr_wr_sel_d;
  logic [DW-1:0]   sdr_din_q, sdr_din_d;
  logic [DW-1:0]   rq_dout_q, rq_dout_d;
  logic            busy_q, busy_d;

  logic [NREQ-1:0] pend;
  logic [1:0]      pick_idx;
  logic            pick_any;
  logic [AW-1:0]   sel_addr;
  logic [1:0]      sel_wr_sel;
  logic [DW-1:0]   sel_din;

  assign pend = rq_req ^ rq_ack_q;

  m72_rr_pick #(.NREQ(NREQ)) u_pick (
    .pend   (pend),
    .rr_ptr (rr_ptr_q),
    .grant  (pick_idx),
    .any    (pick_any)
  );

  // Payload of the latched owner.
  always_comb begin
    sel_addr   = '0;
    sel_wr_sel = '0;
    sel_din    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_q == i[1:0]) begin
        sel_addr   = rq_addr[i*AW +: AW];
        sel_wr_sel = rq_wr_sel[i*2 +: 2];
        sel_din    = rq_din[i*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rq_ack_d     = rq_ack_q;
    owner_d      = owner_q;
    rr_ptr_d     = rr_ptr_q;
    sdr_req_d    = sdr_req_q;
    sdr_addr_d   = sdr_addr_q;
    sdr_wr_sel_d = sdr_wr_sel_q;
    sdr_din_d    = sdr_din_q;
    rq_dout_d    = rq_dout_q;
    busy_d       = busy_q;
    case (state_q)
      ARB_IDLE: begin
        // New arrivals are only arbitrated here, never mid-transaction.
        if (pick_any) begin
          owner_d = pick_idx;
          state_d = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        sdr_addr_d   = sel_addr;
        sdr_wr_sel_d = sel_wr_sel;
        sdr_din_d    = sel_din;
        sdr_req_d    = ~sdr_req_q;
        busy_d       = 1'b1;
        state_d      = ARB_WAIT;
      end
      ARB_WAIT: begin
        // Captured on writes too; the owner simply ignores it.
        if (sdr_ack == sdr_req_q) begin
          rq_dout_d = sdr_dout;
          state_d   = ARB_DONE;
        end
      end
      ARB_DONE: begin
        for (int i = 0; i < NREQ; i++) begin
          if (owner_q == i[1:0]) rq_ack_d[i] = ~rq_ack_q[i];
        end
        // Start the next search past the winner so a re-request cannot win twice.
        rr_ptr_d = rr_next(owner_q, NREQ);
        busy_d   = 1'b0;
        state_d  = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge CLK_32M or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ARB_IDLE;
      rq_ack_q     <= '0;
      owner_q      <= 2'd0;
      rr_ptr_q     <= 2'd0;
      sdr_req_q    <= 1'b0;
      sdr_addr_q   <= '0;
      sdr_wr_sel_q <= 2'b00;
      sdr_din_q    <= '0;
      rq_dout_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rq_ack_q     <= rq_ack_d;
      owner_q      <= owner_d;
      rr_ptr_q     <= rr_ptr_d;
      sdr_req_q    <= sdr_req_d;
      sdr_addr_q   <= sdr_addr_d;
      sdr_wr_sel_q <= sdr_wr_sel_d;
      sdr_din_q    <= sdr_din_d;
      rq_dout_q    <= rq_dout_d;
      busy_q       <= busy_d;
    end
  end

  assign rq_ack     = rq_ack_q;
  assign rq_dout    = rq_dout_q;
  assign rq_owner   = owner_q;
  assign sdr_req    = sdr_req_q;
  assign sdr_addr   = sdr_addr_q;
  assign sdr_wr_sel = sdr_wr_sel_q;
  assign sdr_din    = sdr_din_q;
  assign busy       = busy_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_m72_sdr_arbiter.sv
// Bench for m72_sdr_arbiter: directed scenarios plus a short random mix,
// with an SDRAM toggle-port model and per-requester reference memory.
module tb_m72_sdr_arbiter;
  import m72_pkg::*;

  localparam int NREQ = 3;
  localparam int AW   = 24;
  localparam int DW   = 16;

  // ---------------- clock / reset ----------------
  logic CLK_32M = 1'b0;
  logic reset_n = 1'b0;
  always #15 CLK_32M = ~CLK_32M;

  int cyc = 0;
  always @(posedge CLK_32M) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic [NREQ-1:0]    rq_req = '0;
  logic [NREQ-1:0]    rq_ack;
  logic [NREQ*AW-1:0] rq_addr = '0;
  logic [NREQ*2-1:0]  rq_wr_sel = '0;
  logic [NREQ*DW-1:0] rq_din = '0;
  logic [DW-1:0]      rq_dout;
  logic [1:0]         rq_owner;
  logic               sdr_req;
  logic               sdr_ack;
  logic [AW-1:0]      sdr_addr;
  logic [1:0]         sdr_wr_sel;
  logic [DW-1:0]      sdr_din;
  logic [DW-1:0]      sdr_dout;
  logic               busy;
  arb_state_e         dbg_state;

  m72_sdr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .CLK_32M    (CLK_32M),
    .reset_n    (reset_n),
    .rq_req     (rq_req),
    .rq_ack     (rq_ack),
    .rq_addr    (rq_addr),
    .rq_wr_sel  (rq_wr_sel),
    .rq_din     (rq_din),
    .rq_dout    (rq_dout),
    .rq_owner   (rq_owner),
    .sdr_req    (sdr_req),
    .sdr_ack    (sdr_ack),
    .sdr_addr   (sdr_addr),
    .sdr_wr_sel (sdr_wr_sel),
    .sdr_din    (sdr_din),
    .sdr_dout   (sdr_dout),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] sdr_mem [logic [AW-1:0]];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [1:0]    exp_q[$];
  int            served_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                          input logic [1:0] ws);
    logic [DW-1:0] r;
    r = old;
    if (ws[1]) r[15:8] = d[15:8];
    if (ws[0]) r[7:0]  = d[7:0];
    return r;
  endfunction

  // ---------------- SDRAM model ----------------
  int            mdl_lat  = 5;
  bit            mdl_rand = 1'b0;
  int            sdr_toggles = 0;
  int            sdr_seen_cyc = 0;
  int            ack_cyc = 0;
  logic [AW-1:0] last_addr = '0;
  logic [1:0]    last_ws = '0;
  logic [DW-1:0] last_din = '0;
  logic          last_busy = 1'b0;

  initial begin
    bit            aborted;
    int            lat;
    logic [DW-1:0] old;
    sdr_ack  = 1'b0;
    sdr_dout = '0;
    forever begin
      @(negedge CLK_32M);
      if (!reset_n) sdr_ack = 1'b0;
      else if (sdr_req != sdr_ack) begin
        sdr_toggles++;
        sdr_seen_cyc = cyc;
        last_addr    = sdr_addr;
        last_ws      = sdr_wr_sel;
        last_din     = sdr_din;
        last_busy    = busy;
        lat = mdl_rand ? int'($urandom_range(1, 6)) : mdl_lat;
        aborted = 1'b0;
        for (int k = 0; k < lat; k++) begin
          @(negedge CLK_32M);
          if (!reset_n) begin
            aborted = 1'b1;
            break;
          end
        end
        if (aborted) sdr_ack = 1'b0;
        else begin
          old = sdr_mem.exists(last_addr) ? sdr_mem[last_addr] : pat(last_addr);
          if (last_ws != 2'b00) sdr_mem[last_addr] = merge(old, last_din, last_ws);
          sdr_dout = old;
          sdr_ack  = ~sdr_ack;
          ack_cyc  = cyc;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  int rq_ack_cyc = 0;
  initial begin
    logic [NREQ-1:0] p_ack;
    logic            p_req, p_sack;
    p_ack = '0; p_req = 1'b0; p_sack = 1'b0;
    forever begin
      @(posedge CLK_32M); #1;
      if (reset_n) begin
        if (sdr_req != p_req) check("one_outstanding", 32'(p_req ^ p_sack), 32'd0);
        for (int i = 0; i < NREQ; i++) begin
          if (rq_ack[i] != p_ack[i]) begin
            served_q.push_back(i);
            rq_ack_cyc = cyc;
            check("ack_owner", 32'(rq_owner), i);
          end
        end
      end
      p_ack = rq_ack; p_req = sdr_req; p_sack = sdr_ack;
    end
  end

  // ---------------- driver tasks ----------------
  int req_cyc = 0;

  task automatic txn(input int p, input logic [AW-1:0] a, input logic [1:0] ws,
                     input logic [DW-1:0] d, output logic [DW-1:0] q);
    bit done;
    done = 1'b0;
    rq_addr[p*AW +: AW]  = a;
    rq_wr_sel[p*2 +: 2]  = ws;
    rq_din[p*DW +: DW]   = d;
    rq_req[p]            = ~rq_req[p];
    req_cyc              = cyc;
    for (int k = 0; k < 300; k++) begin
      @(negedge CLK_32M);
      if (rq_ack[p] == rq_req[p]) begin
        done = 1'b1;
        break;
      end
    end
    q = rq_dout;
    check($sformatf("ack_seen_p%0d", p), 32'(done), 32'd1);
  endtask

  task automatic rand_port(input int p, input int n);
    logic [AW-1:0] a;
    logic [1:0]    ws;
    logic [DW-1:0] d, q, e;
    for (int t = 0; t < n; t++) begin
      a  = {4'(p), 12'h000, 8'($urandom_range(0, 15))};
      ws = ($urandom_range(0, 1) == 1) ? 2'($urandom_range(1, 3)) : 2'b00;
      d  = 16'($urandom);
      e  = ref_mem.exists(a) ? ref_mem[a] : pat(a);
      if (ws != 2'b00) ref_mem[a] = merge(e, d, ws);
      txn(p, a, ws, d, q);
      if (ws == 2'b00) check($sformatf("rand_rd_p%0d", p), 32'(q), 32'(e));
      repeat ($urandom_range(0, 3)) @(negedge CLK_32M);
    end
  endtask

  task automatic check_order(input string tag);
    check({tag, "_count"}, served_q.size(), exp_q.size());
    while (exp_q.size() > 0 && served_q.size() > 0)
      check(tag, served_q.pop_front(), 32'(exp_q.pop_front()));
    exp_q.delete();
    served_q.delete();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached, n_pass=%0d n_checks=%0d", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [DW-1:0] q, q0, q1, q2;
    int base;

    repeat (3) @(negedge CLK_32M);
    check("rst_rq_ack", 32'(rq_ack), 32'd0);
    check("rst_sdr_req", 32'(sdr_req), 32'd0);
    check("rst_sdr_addr", 32'(sdr_addr), 32'd0);
    check("rst_sdr_wr_sel", 32'(sdr_wr_sel), 32'd0);
    check("rst_sdr_din", 32'(sdr_din), 32'd0);
    check("rst_rq_dout", 32'(rq_dout), 32'd0);
    check("rst_rq_owner", 32'(rq_owner), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ARB_IDLE));
    reset_n = 1'b1;
    @(negedge CLK_32M);

    // Single read on port 0, 5-cycle SDRAM.
    sdr_mem[24'h012345] = 16'hBEEF;
    base = sdr_toggles;
    txn(0, 24'h012345, 2'b00, 16'h0000, q);
    check("t1_dout", 32'(q), 32'hBEEF);
    check("t1_sdr_toggles", sdr_toggles - base, 1);
    check("t1_sdr_addr", 32'(last_addr), 32'h012345);
    check("t1_sdr_wr_sel", 32'(last_ws), 32'd0);
    check("t1_rq_ack", 32'(rq_ack), 32'b001);
    check("t1_req_latency", sdr_seen_cyc - req_cyc, 2);
    check("t1_ack_latency", rq_ack_cyc - ack_cyc, 2);
    check("t1_busy_inflight", 32'(last_busy), 32'd1);
    check("t1_busy_after", 32'(busy), 32'd0);
    exp_q.push_back(2'd0);
    check_order("t1_order");

    // Byte write on port 1, then read it back.
    txn(1, 24'h200010, 2'b10, 16'hA55A, q);
    check("t4_sdr_wr_sel", 32'(last_ws), 32'b10);
    check("t4_sdr_din", 32'(last_din), 32'hA55A);
    check("t4_sdr_addr", 32'(last_addr), 32'h200010);
    check("t4_rq_ack", 32'(rq_ack), 32'b011);
    check("t4_wr_sel_held", 32'(sdr_wr_sel), 32'b10);
    txn(1, 24'h200010, 2'b00, 16'h0000, q);
    check("t4_readback", 32'(q), 32'hA54A);

    // Port 2 read moves the round-robin pointer back to 0.
    txn(2, 24'h300000, 2'b00, 16'h0000, q);
    check("t2_pre_dout", 32'(q), 32'h5A5A);
    check("t2_pre_owner", 32'(rq_owner), 32'd2);
    check("t2_pre_rq_ack", 32'(rq_ack), 32'b101);
    served_q.delete();

    // All three ports request in the same cycle.
    base = sdr_toggles;
    fork
      txn(0, 24'h000011, 2'b00, 16'h0000, q0);
      txn(1, 24'h200022, 2'b00, 16'h0000, q1);
      txn(2, 24'h300033, 2'b00, 16'h0000, q2);
    join
    check("t2_dout0", 32'(q0), 32'h5A4B);
    check("t2_dout1", 32'(q1), 32'h5A78);
    check("t2_dout2", 32'(q2), 32'h5A69);
    check("t2_sdr_toggles", sdr_toggles - base, 3);
    check("t2_last_owner", 32'(rq_owner), 32'd2);
    exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
    check_order("t2_order");

    // Port 0 re-requests right after each ack while port 2 is pending.
    fork
      begin
        txn(0, 24'h000040, 2'b00, 16'h0000, q0);
        txn(0, 24'h000041, 2'b00, 16'h0000, q0);
      end
      begin
        txn(2, 24'h300040, 2'b00, 16'h0000, q2);
        txn(2, 24'h300041, 2'b00, 16'h0000, q2);
      end
    join
    exp_q.push_back(2'd0); exp_q.push_back(2'd2); exp_q.push_back(2'd0); exp_q.push_back(2'd2);
    check_order("t3_order");

    // Reset while waiting on the SDRAM.
    mdl_lat = 8;
    rq_addr[0 +: AW] = 24'h00ABCD;
    rq_wr_sel[0 +: 2] = 2'b00;
    rq_req[0] = ~rq_req[0];
    repeat (2) @(negedge CLK_32M);
    check("t5_in_wait", 32'(dbg_state), 32'(ARB_WAIT));
    check("t5_busy_wait", 32'(busy), 32'd1);
    reset_n = 1'b0;
    rq_req  = '0;
    #1;
    check("t5_rq_ack", 32'(rq_ack), 32'd0);
    check("t5_sdr_req", 32'(sdr_req), 32'd0);
    check("t5_sdr_addr", 32'(sdr_addr), 32'd0);
    check("t5_sdr_wr_sel", 32'(sdr_wr_sel), 32'd0);
    check("t5_sdr_din", 32'(sdr_din), 32'd0);
    check("t5_rq_dout", 32'(rq_dout), 32'd0);
    check("t5_rq_owner", 32'(rq_owner), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_state", 32'(dbg_state), 32'(ARB_IDLE));
    repeat (3) @(negedge CLK_32M);
    reset_n = 1'b1;
    @(negedge CLK_32M);
    mdl_lat = 5;
    served_q.delete();
    txn(2, 24'h30ABCD, 2'b00, 16'h0000, q);
    check("t5_post_dout", 32'(q), 32'hF197);
    check("t5_post_owner", 32'(rq_owner), 32'd2);
    check("t5_post_rq_ack", 32'(rq_ack), 32'b100);
    served_q.delete();

    // Random mix on all ports, each in its own address region.
    mdl_rand = 1'b1;
    fork
      rand_port(0, 100);
      rand_port(1, 100);
      rand_port(2, 100);
    join
    repeat (4) @(negedge CLK_32M);
    check("t6_idle_busy", 32'(busy), 32'd0);
    check("t6_idle_state", 32'(dbg_state), 32'(ARB_IDLE));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
